// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory program loader.
package imem_loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LEN_LO,
    LEN_HI,
    DATA,
    CHK,
    DONE,
    ERR
  } state_t;

  localparam int BYTES_PER_WORD = 4;
  localparam int LEN_W          = 16;

endpackage

// File: rtl/loader_xor_accum.sv
// 8-bit XOR accumulator with synchronous clear and enable.
module loader_xor_accum (
  input  logic       clk,
  input  logic       reset,
  input  logic       clr,
  input  logic       en,
  input  logic [7:0] din,
  output logic [7:0] acc
);

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      acc <= '0;
    end else if (en) begin
      acc <= acc ^ din;
    end
  end

endmodule

// File: rtl/imem_program_loader.sv
// Framed byte-stream loader: length/checksum check, byte writes into
// instruction memory, and core hold until a frame loads cleanly.
module imem_program_loader
  import imem_loader_pkg::*;
#(
  parameter int MEM_BYTES = 36,
  parameter int ADDR_W    = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [7:0]        byte_in,
  input  logic              byte_valid,
  output logic              byte_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic              cpu_hold
);

  localparam logic [17:0] MEM_LIMIT = 18'(MEM_BYTES);

  state_t           state;
  state_t           state_nxt;
  logic [LEN_W-1:0] count;
  logic [17:0]      idx;
  logic [17:0]      total;
  logic [17:0]      len_total;
  logic [7:0]       acc;
  logic             accept;
  logic             restart;
  logic             lat_lo;
  logic             lat_hi;
  logic             wr;

  assign byte_ready = (state == LEN_LO) || (state == LEN_HI) ||
                      (state == DATA)   || (state == CHK);
  assign accept     = byte_valid && byte_ready;
  assign restart    = start && ((state == IDLE) || (state == DONE) ||
                                (state == ERR));

  // 18-bit byte totals so 4*count cannot wrap
  assign total      = 18'(count) * 18'(BYTES_PER_WORD);
  assign len_total  = 18'({byte_in, count[7:0]}) * 18'(BYTES_PER_WORD);

  assign busy       = byte_ready;
  assign done       = (state == DONE);
  assign error      = (state == ERR);
  assign cpu_hold   = (state != DONE);

  always_comb begin
    state_nxt = state;
    lat_lo    = 1'b0;
    lat_hi    = 1'b0;
    wr        = 1'b0;
    unique case (state)
      IDLE, DONE, ERR: begin
        if (start) state_nxt = LEN_LO;
      end
      LEN_LO: begin
        if (accept) begin
          lat_lo    = 1'b1;
          state_nxt = LEN_HI;
        end
      end
      LEN_HI: begin
        if (accept) begin
          lat_hi = 1'b1;
          if (len_total > MEM_LIMIT) state_nxt = ERR;
          else if (len_total == '0) state_nxt = CHK;
          else state_nxt = DATA;
        end
      end
      DATA: begin
        if (accept) begin
          wr = 1'b1;
          if (idx == total - 18'd1) state_nxt = CHK;
        end
      end
      CHK: begin
        if (accept) state_nxt = (byte_in == acc) ? DONE : ERR;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      count     <= '0;
      idx       <= '0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      state  <= state_nxt;
      mem_we <= wr;
      if (wr) begin
        mem_addr  <= ADDR_W'(idx);
        mem_wdata <= byte_in;
        idx       <= idx + 18'd1;
      end
      if (lat_lo) count[7:0]  <= byte_in;
      if (lat_hi) count[15:8] <= byte_in;
      if (restart) begin
        count    <= '0;
        idx      <= '0;
        mem_addr <= '0;
      end
    end
  end

  loader_xor_accum u_xor (
    .clk   (clk),
    .reset (reset),
    .clr   (restart),
    .en    (wr),
    .din   (byte_in),
    .acc   (acc)
  );

endmodule

// File: tb/tb_imem_program_loader.sv
// Scoreboard bench for imem_program_loader: directed frames plus random
// frames checked against a frame-level reference model.
module tb_imem_program_loader;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  byte_in = '0;
  logic        byte_valid = 1'b0;
  logic        byte_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        busy;
  logic        done;
  logic        error;
  logic        cpu_hold;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [31:0] addr;
    logic [7:0]  data;
  } wr_t;

  wr_t       exp_q[$];
  logic [7:0] frame[$];
  bit        exp_done;
  bit        exp_err;

  always #5 clk = ~clk;

  imem_program_loader #(.MEM_BYTES(36), .ADDR_W(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .byte_in    (byte_in),
    .byte_valid (byte_valid),
    .byte_ready (byte_ready),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .busy       (busy),
    .done       (done),
    .error      (error),
    .cpu_hold   (cpu_hold)
  );

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Monitor: every write strobe must match the head of the scoreboard
  always @(negedge clk) begin
    if (mem_we) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_write", mem_addr, 32'hFFFF_FFFF);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        chk("wr_addr", mem_addr, e.addr);
        chk("wr_data", 32'(mem_wdata), 32'(e.data));
      end
    end
    if (done && error) chk("done_and_error", 32'(1), 32'(0));
  end

  task automatic start_pulse();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gap);
    int n;
    if (gap) begin
      byte_valid = 1'b0;
      @(posedge clk); #1;
    end
    byte_valid = 1'b1;
    byte_in    = b;
    n = 0;
    while (!byte_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (!byte_ready) chk("ready_timeout", 32'(0), 32'(1));
    @(posedge clk); #1;
    byte_valid = 1'b0;
  endtask

  // Reference model: derive writes and outcome from the frame contents
  task automatic model_frame(output int nsend);
    int len;
    logic [7:0] x;
    len = int'(frame[0]) + 256 * int'(frame[1]);
    x = 8'h00;
    exp_done = 1'b0;
    exp_err  = 1'b0;
    if (len * 4 > 36) begin
      exp_err = 1'b1;
      nsend = 2;
    end else begin
      for (int i = 0; i < len * 4; i++) begin
        exp_q.push_back('{addr: 32'(i), data: frame[2 + i]});
        x = x ^ frame[2 + i];
      end
      nsend = 3 + len * 4;
      if (x == frame[2 + len * 4]) exp_done = 1'b1;
      else exp_err = 1'b1;
    end
  endtask

  task automatic build_frame(input int len, input bit good);
    logic [7:0] x;
    logic [7:0] b;
    frame.delete();
    frame.push_back(8'(len));
    frame.push_back(8'(len >> 8));
    x = 8'h00;
    if (len * 4 <= 36) begin
      for (int i = 0; i < len * 4; i++) begin
        b = 8'($urandom);
        frame.push_back(b);
        x = x ^ b;
      end
      frame.push_back(good ? x : ~x);
    end
  endtask

  task automatic run_frame(input string tag, input bit gaps,
                           input bit mid_start);
    int nsend;
    model_frame(nsend);
    start_pulse();
    chk({tag, "_hold_on_start"}, 32'(cpu_hold), 32'(1));
    chk({tag, "_busy_on_start"}, 32'(busy), 32'(1));
    for (int i = 0; i < nsend; i++) begin
      if (mid_start && i == 4) start = 1'b1;
      send_byte(frame[i], gaps && (i % 2 == 1));
      start = 1'b0;
    end
    // A few stray valid cycles after the frame must not write
    byte_valid = 1'b1;
    byte_in    = 8'h5A;
    repeat (3) @(posedge clk);
    #1;
    byte_valid = 1'b0;
    chk({tag, "_drained"}, 32'(exp_q.size()), 32'(0));
    chk({tag, "_done"}, 32'(done), 32'(exp_done));
    chk({tag, "_error"}, 32'(error), 32'(exp_err));
    chk({tag, "_busy"}, 32'(busy), 32'(0));
    chk({tag, "_hold"}, 32'(cpu_hold), 32'(!exp_done));
    exp_q.delete();
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", 32'(byte_ready), 32'(0));
    chk("rst_we", 32'(mem_we), 32'(0));
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_done", 32'(done), 32'(0));
    chk("rst_error", 32'(error), 32'(0));
    chk("rst_addr", mem_addr, 32'(0));
    chk("rst_wdata", 32'(mem_wdata), 32'(0));
    chk("rst_hold", 32'(cpu_hold), 32'(1));
    reset = 1'b0;
    @(posedge clk); #1;

    // Known-good frame, checksum 0xA6
    frame = '{8'h02, 8'h00, 8'h20, 8'h10, 8'h01, 8'h00,
              8'h22, 8'h30, 8'h85, 8'h00, 8'hA6};
    run_frame("t1", 1'b0, 1'b0);
    frame[10] = 8'h00;
    run_frame("t2", 1'b0, 1'b0);

    // Length boundary: 40 bytes rejected, 36 bytes accepted
    build_frame(10, 1'b1);
    run_frame("t3_len10", 1'b0, 1'b0);
    build_frame(9, 1'b1);
    run_frame("t3_len9", 1'b0, 1'b0);
    build_frame(256 + 1, 1'b1);
    run_frame("t3_lenhi", 1'b0, 1'b0);

    frame = '{8'h00, 8'h00, 8'h00};
    run_frame("t4_len0", 1'b0, 1'b0);

    // Gapped valid, then start pulsed during DATA
    build_frame(3, 1'b1);
    run_frame("t5_gaps", 1'b1, 1'b0);
    build_frame(3, 1'b1);
    run_frame("t5_midstart", 1'b0, 1'b1);

    // Reset after the third payload byte
    build_frame(2, 1'b1);
    for (int i = 0; i < 3; i++)
      exp_q.push_back('{addr: 32'(i), data: frame[2 + i]});
    start_pulse();
    for (int i = 0; i < 5; i++) send_byte(frame[i], 1'b0);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("t6_busy", 32'(busy), 32'(0));
    chk("t6_hold", 32'(cpu_hold), 32'(1));
    chk("t6_ready", 32'(byte_ready), 32'(0));
    chk("t6_we", 32'(mem_we), 32'(0));
    chk("t6_drained", 32'(exp_q.size()), 32'(0));
    exp_q.delete();
    build_frame(2, 1'b1);
    run_frame("t6_reload", 1'b0, 1'b0);

    // Random frames
    for (int k = 0; k < 16; k++) begin
      build_frame($urandom_range(0, 11), $urandom_range(0, 3) != 0);
      run_frame("rnd", $urandom_range(0, 1) == 1, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
